// File: rtl/l2_req_out_queue_pkg.sv
// Shared cache types for the L2 request-out path, plus the queued entry
// layout so the NoC side can reuse it.
package l2_req_out_queue_pkg;

  localparam int LINE_ADDR_BITS = 28;
  localparam int BITS_PER_LINE  = 128;
  localparam int HPROT_WIDTH    = 2;

  typedef logic [LINE_ADDR_BITS-1:0] line_addr_t;
  typedef logic [BITS_PER_LINE-1:0]  line_t;
  typedef logic [HPROT_WIDTH-1:0]    hprot_t;

  typedef enum logic [2:0] {
    REQ_GETS = 3'd0,
    REQ_GETM = 3'd1,
    REQ_PUTS = 3'd2,
    REQ_PUTM = 3'd3,
    REQ_WB   = 3'd4
  } coh_msg_t;

  typedef struct packed {
    coh_msg_t   coh_msg;
    hprot_t     hprot;
    line_addr_t addr;
    line_t      line;
  } l2_req_out_entry_t;

endpackage

// File: rtl/l2_req_out_queue_sync_fifo.sv
// Generic synchronous FIFO: DEPTH x WIDTH storage, natural-wrap pointers,
// occupancy counter. Callers must only push when !full and pop when !empty.
module l2_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CNT_W-1:0] occupancy_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Next pointers and occupancy; a simultaneous push and pop keeps the count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; contents are only observed when non-empty.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o     = mem_q[rd_ptr_q];
  assign occupancy_o = count_q;
  assign full_o      = (count_q == CNT_W'(DEPTH));
  assign empty_o     = (count_q == '0);

endmodule

// File: rtl/l2_req_out_queue.sv
// Request-out buffer between the L2 and the NoC: decouples back-pressure
// with a FIFO and caps requests in flight toward the LLC/directory.
module l2_req_out_queue
  import l2_req_out_queue_pkg::*;
#(
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = $clog2(DEPTH+1),
  parameter int OUT_W           = $clog2(MAX_OUTSTANDING+1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  coh_msg_t                  in_coh_msg,
  input  logic [HPROT_WIDTH-1:0]    in_hprot,
  input  logic [LINE_ADDR_BITS-1:0] in_addr,
  input  logic [BITS_PER_LINE-1:0]  in_line,
  output logic                      out_valid,
  input  logic                      out_ready,
  output coh_msg_t                  out_coh_msg,
  output logic [HPROT_WIDTH-1:0]    out_hprot,
  output logic [LINE_ADDR_BITS-1:0] out_addr,
  output logic [BITS_PER_LINE-1:0]  out_line,
  input  logic                      rsp_done,
  output logic [CNT_W-1:0]          occupancy,
  output logic [OUT_W-1:0]          outstanding,
  output logic                      idle,
  output logic                      err_underflow
);

  localparam int ENTRY_W = $bits(l2_req_out_entry_t);

  l2_req_out_entry_t  wr_entry;
  l2_req_out_entry_t  head_entry;
  l2_req_out_entry_t  head_vis;
  logic [ENTRY_W-1:0] head_raw;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic               throttled;
  logic [OUT_W-1:0]   outs_q, outs_d;
  logic               err_q, err_d;

  assign wr_entry = '{coh_msg: in_coh_msg, hprot: in_hprot, addr: in_addr, line: in_line};

  // in_ready comes from registered occupancy only, never from out_ready.
  assign throttled = (outs_q == OUT_W'(MAX_OUTSTANDING));
  assign in_ready  = !fifo_full;
  assign out_valid = !fifo_empty && !throttled;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  l2_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .pop_i       (pop),
    .wdata_i     (wr_entry),
    .rdata_o     (head_raw),
    .occupancy_o (occupancy),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // Head is zeroed while empty so stale storage never leaks onto out_*.
  assign head_entry = l2_req_out_entry_t'(head_raw);
  assign head_vis   = fifo_empty ? '0 : head_entry;

  assign out_coh_msg = head_vis.coh_msg;
  assign out_hprot   = head_vis.hprot;
  assign out_addr    = head_vis.addr;
  assign out_line    = head_vis.line;

  // In-flight accounting: issue increments, completion decrements; a
  // completion with nothing in flight holds at zero and flags underflow.
  always_comb begin
    outs_d = outs_q;
    err_d  = err_q;
    case ({pop, rsp_done})
      2'b10: outs_d = outs_q + OUT_W'(1);
      2'b01: begin
        if (outs_q == '0) err_d  = 1'b1;
        else              outs_d = outs_q - OUT_W'(1);
      end
      default: outs_d = outs_q;
    endcase
  end

  // Outstanding counter and sticky underflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outs_q <= '0;
      err_q  <= 1'b0;
    end else begin
      outs_q <= outs_d;
      err_q  <= err_d;
    end
  end

  assign outstanding   = outs_q;
  assign err_underflow = err_q;
  assign idle          = fifo_empty && (outs_q == '0);

endmodule

// File: tb/tb_l2_req_out_queue.sv
// Directed bench for l2_req_out_queue: vector table plus hand sequences
// for throttling and asynchronous reset.
module tb_l2_req_out_queue;
  import l2_req_out_queue_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  coh_msg_t   in_coh_msg = REQ_GETM;
  logic [1:0] in_hprot = 2'b01;
  logic [27:0] in_addr = '0;
  logic [127:0] in_line = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  coh_msg_t   out_coh_msg;
  logic [1:0] out_hprot;
  logic [27:0] out_addr;
  logic [127:0] out_line;
  logic       rsp_done = 1'b0;
  logic [2:0] occupancy;
  logic [2:0] outstanding;
  logic       idle;
  logic       err_underflow;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  l2_req_out_queue dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_coh_msg   (in_coh_msg),
    .in_hprot     (in_hprot),
    .in_addr      (in_addr),
    .in_line      (in_line),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_coh_msg  (out_coh_msg),
    .out_hprot    (out_hprot),
    .out_addr     (out_addr),
    .out_line     (out_line),
    .rsp_done     (rsp_done),
    .occupancy    (occupancy),
    .outstanding  (outstanding),
    .idle         (idle),
    .err_underflow(err_underflow)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Bench-side properties: head stable under back-pressure, no push into a full queue.
  logic        hold_prev = 1'b0;
  logic [27:0] addr_prev = '0;
  always @(negedge clk) begin
    if (rst) hold_prev <= 1'b0;
    else begin
      if (hold_prev && out_valid) chk("stable_addr", 128'(out_addr), 128'(addr_prev));
      if (in_valid && !in_ready) chk("push_when_full", 128'(in_valid), 128'(0));
      hold_prev <= out_valid && !out_ready;
      addr_prev <= out_addr;
    end
  end

  typedef struct {
    logic        iv;
    logic [27:0] addr;
    logic        ordy;
    logic        rsp;
    logic [2:0]  occ;
    logic [2:0]  outs;
    logic        ov;
    logic        ir;
    logic        idl;
    logic        err;
    logic [27:0] oaddr;
  } vec_t;

  function automatic vec_t mk(logic iv, logic [27:0] addr, logic ordy, logic rsp,
                              logic [2:0] occ, logic [2:0] outs, logic ov, logic ir,
                              logic idl, logic err, logic [27:0] oaddr);
    vec_t v;
    v.iv = iv; v.addr = addr; v.ordy = ordy; v.rsp = rsp;
    v.occ = occ; v.outs = outs; v.ov = ov; v.ir = ir;
    v.idl = idl; v.err = err; v.oaddr = oaddr;
    return v;
  endfunction

  task automatic drive(input logic iv, input logic [27:0] addr, input logic ordy, input logic rsp);
    in_valid  = iv;
    in_addr   = addr;
    in_line   = {100'b0, addr};
    out_ready = ordy;
    rsp_done  = rsp;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, '0, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  vec_t vecs[30];
  int   pops;

  initial begin
    vecs[0]  = mk(1, 28'h40, 1, 0, 0, 0, 0, 1, 1, 0, 28'h00);
    vecs[1]  = mk(0, 28'h00, 1, 0, 1, 0, 1, 1, 0, 0, 28'h40);
    vecs[2]  = mk(0, 28'h00, 1, 1, 0, 1, 0, 1, 0, 0, 28'h00);
    vecs[3]  = mk(0, 28'h00, 0, 0, 0, 0, 0, 1, 1, 0, 28'h00);
    vecs[4]  = mk(1, 28'h10, 0, 0, 0, 0, 0, 1, 1, 0, 28'h00);
    vecs[5]  = mk(1, 28'h20, 0, 0, 1, 0, 1, 1, 0, 0, 28'h10);
    vecs[6]  = mk(1, 28'h30, 0, 0, 2, 0, 1, 1, 0, 0, 28'h10);
    vecs[7]  = mk(1, 28'h40, 0, 0, 3, 0, 1, 1, 0, 0, 28'h10);
    vecs[8]  = mk(0, 28'h00, 1, 0, 4, 0, 1, 0, 0, 0, 28'h10);
    vecs[9]  = mk(0, 28'h00, 1, 0, 3, 1, 1, 1, 0, 0, 28'h20);
    vecs[10] = mk(0, 28'h00, 1, 0, 2, 2, 1, 1, 0, 0, 28'h30);
    vecs[11] = mk(0, 28'h00, 1, 0, 1, 3, 1, 1, 0, 0, 28'h40);
    vecs[12] = mk(0, 28'h00, 0, 1, 0, 4, 0, 1, 0, 0, 28'h00);
    vecs[13] = mk(0, 28'h00, 0, 1, 0, 3, 0, 1, 0, 0, 28'h00);
    vecs[14] = mk(0, 28'h00, 0, 1, 0, 2, 0, 1, 0, 0, 28'h00);
    vecs[15] = mk(0, 28'h00, 0, 1, 0, 1, 0, 1, 0, 0, 28'h00);
    vecs[16] = mk(1, 28'h50, 0, 0, 0, 0, 0, 1, 1, 0, 28'h00);
    vecs[17] = mk(1, 28'h60, 0, 0, 1, 0, 1, 1, 0, 0, 28'h50);
    vecs[18] = mk(0, 28'h00, 1, 0, 2, 0, 1, 1, 0, 0, 28'h50);
    vecs[19] = mk(0, 28'h00, 1, 0, 1, 1, 1, 1, 0, 0, 28'h60);
    vecs[20] = mk(1, 28'h70, 0, 0, 0, 2, 0, 1, 0, 0, 28'h00);
    vecs[21] = mk(1, 28'h80, 0, 0, 1, 2, 1, 1, 0, 0, 28'h70);
    vecs[22] = mk(1, 28'h90, 1, 1, 2, 2, 1, 1, 0, 0, 28'h70);
    vecs[23] = mk(0, 28'h00, 0, 0, 2, 2, 1, 1, 0, 0, 28'h80);
    vecs[24] = mk(0, 28'h00, 1, 1, 2, 2, 1, 1, 0, 0, 28'h80);
    vecs[25] = mk(0, 28'h00, 1, 1, 1, 2, 1, 1, 0, 0, 28'h90);
    vecs[26] = mk(0, 28'h00, 0, 1, 0, 2, 0, 1, 0, 0, 28'h00);
    vecs[27] = mk(0, 28'h00, 0, 1, 0, 1, 0, 1, 0, 0, 28'h00);
    vecs[28] = mk(0, 28'h00, 0, 1, 0, 0, 0, 1, 1, 0, 28'h00);
    vecs[29] = mk(0, 28'h00, 0, 0, 0, 0, 0, 1, 1, 1, 28'h00);

    do_reset();
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_idle", 128'(idle), 128'(1));
    chk("rst_out_line", out_line, 128'(0));

    for (int i = 0; i < 30; i++) begin
      drive(vecs[i].iv, vecs[i].addr, vecs[i].ordy, vecs[i].rsp);
      chk($sformatf("v%0d_occ", i), 128'(occupancy), 128'(vecs[i].occ));
      chk($sformatf("v%0d_outs", i), 128'(outstanding), 128'(vecs[i].outs));
      chk($sformatf("v%0d_out_valid", i), 128'(out_valid), 128'(vecs[i].ov));
      chk($sformatf("v%0d_in_ready", i), 128'(in_ready), 128'(vecs[i].ir));
      chk($sformatf("v%0d_idle", i), 128'(idle), 128'(vecs[i].idl));
      chk($sformatf("v%0d_err", i), 128'(err_underflow), 128'(vecs[i].err));
      chk($sformatf("v%0d_out_addr", i), 128'(out_addr), 128'(vecs[i].oaddr));
      chk($sformatf("v%0d_out_line", i), out_line, {100'b0, vecs[i].oaddr});
      chk($sformatf("v%0d_out_msg", i), 128'(out_coh_msg),
          (vecs[i].occ != 0) ? 128'(REQ_GETM) : 128'(0));
      chk($sformatf("v%0d_out_hprot", i), 128'(out_hprot),
          (vecs[i].occ != 0) ? 128'(2'b01) : 128'(0));
      tick();
    end

    // Underflow flag is sticky until reset.
    drive(1'b0, '0, 1'b0, 1'b0);
    repeat (3) tick();
    chk("err_sticky", 128'(err_underflow), 128'(1));
    do_reset();
    chk("err_cleared", 128'(err_underflow), 128'(0));

    // Throttle: six requests streamed with NoC ready, no completions.
    pops = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 28'h100 + 28'(i), 1'b1, 1'b0);
      if (out_valid && out_ready) pops++;
      tick();
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (out_valid && out_ready) pops++;
      tick();
    end
    chk("thr_pops", 128'(pops), 128'(4));
    chk("thr_out_valid", 128'(out_valid), 128'(0));
    chk("thr_occ", 128'(occupancy), 128'(2));
    chk("thr_outs", 128'(outstanding), 128'(4));
    drive(1'b0, '0, 1'b0, 1'b1);
    chk("thr_still_blocked", 128'(out_valid), 128'(0));
    tick();
    drive(1'b0, '0, 1'b1, 1'b0);
    chk("thr_release_valid", 128'(out_valid), 128'(1));
    chk("thr_fifth_addr", 128'(out_addr), 128'(28'h104));
    tick();
    chk("thr_after_pop_outs", 128'(outstanding), 128'(4));
    chk("thr_after_pop_occ", 128'(occupancy), 128'(1));
    chk("thr_after_pop_valid", 128'(out_valid), 128'(0));

    // Asynchronous reset with 3 queued and 2 outstanding.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 28'h200 + 28'(i), (i < 3), 1'b0);
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("pre_rst_occ", 128'(occupancy), 128'(3));
    chk("pre_rst_outs", 128'(outstanding), 128'(2));
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_occ", 128'(occupancy), 128'(0));
    chk("async_rst_outs", 128'(outstanding), 128'(0));
    chk("async_rst_out_valid", 128'(out_valid), 128'(0));
    chk("async_rst_in_ready", 128'(in_ready), 128'(1));
    chk("async_rst_idle", 128'(idle), 128'(1));
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("post_rst%0d_valid", i), 128'(out_valid), 128'(0));
      chk($sformatf("post_rst%0d_addr", i), 128'(out_addr), 128'(0));
      chk($sformatf("post_rst%0d_occ", i), 128'(occupancy), 128'(0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
